// File: rtl/disp_pkg.sv
// Shared constants for the serial 7-segment display driver:
// segment codes, glyph codes and FSM state encoding.
package disp_pkg;

    // Segment bytes {dp,g,f,e,d,c,b,a}, active-high, dp clear
    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_MINUS = 8'h40;
    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_E     = 8'h79;

    // Non-decimal glyph codes
    localparam logic [3:0] BCD_MINUS = 4'hA;
    localparam logic [3:0] BCD_BLANK = 4'hB;

    // FSM states
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] LATCH = 2'd3;

endpackage

// File: rtl/disp_serializer_seg7.sv
// One-digit encoder: BCD/glyph code plus decimal point to a
// segment byte, with blanking and output polarity applied.
module seg7_encoder
    import disp_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic [3:0] code,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);

    logic [7:0] glyph;
    logic [7:0] raw;

    // Code to glyph lookup; C..F all show 'E'
    always_comb begin
        glyph = SEG_E;
        case (code)
            4'h0:      glyph = SEG_0;
            4'h1:      glyph = SEG_1;
            4'h2:      glyph = SEG_2;
            4'h3:      glyph = SEG_3;
            4'h4:      glyph = SEG_4;
            4'h5:      glyph = SEG_5;
            4'h6:      glyph = SEG_6;
            4'h7:      glyph = SEG_7;
            4'h8:      glyph = SEG_8;
            4'h9:      glyph = SEG_9;
            BCD_MINUS: glyph = SEG_MINUS;
            BCD_BLANK: glyph = SEG_BLANK;
            default:   glyph = SEG_E;
        endcase
    end

    // Merge dp, force blank, then apply polarity to all 8 bits
    always_comb begin
        raw = {glyph[7] | dp, glyph[6:0]};
        if (blank) raw = SEG_BLANK;
        seg = ACTIVE_LOW ? ~raw : raw;
    end

endmodule

// File: rtl/disp_serializer.sv
// Snapshots an N-digit BCD word, encodes it to segment bytes and
// shifts the frame out with a generated clock and latch strobe.
module disp_serializer
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 2,
    parameter bit ACTIVE_LOW = 1'b0,
    parameter bit AUTO       = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    input  logic                    start,
    output logic                    ser_data,
    output logic                    ser_clk,
    output logic                    ser_latch,
    output logic                    busy,
    output logic                    done
);

    localparam int FB = 8 * NUM_DIGITS;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (FB > 1) ? $clog2(FB) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_MAX = BW'(FB - 1);

    logic [1:0]            state;
    logic [FB-1:0]         sr;
    logic [FB-1:0]         frame;
    logic [BW-1:0]         bit_cnt;
    logic [DW-1:0]         div_cnt;
    logic                  phase;
    logic                  done_q;
    logic [NUM_DIGITS-1:0] lz;

    // Leading-zero run from the MSD; digit 0 always shown
    always_comb begin
        logic run;
        lz  = '0;
        run = blank_lz;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            run   = run && (bcd_in[4*k +: 4] == 4'h0) && !dp_in[k];
            lz[k] = run && (k != 0);
        end
    end

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
        seg7_encoder #(
            .ACTIVE_LOW(ACTIVE_LOW)
        ) u_enc (
            .code (bcd_in[4*k +: 4]),
            .dp   (dp_in[k]),
            .blank(lz[k]),
            .seg  (frame[8*k +: 8])
        );
    end

    // Frame sequencer: load, per-bit low/high phases, latch window
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sr      <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            phase   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start || AUTO) state <= LOAD;
                end
                LOAD: begin
                    sr      <= frame;
                    bit_cnt <= BIT_MAX;
                    div_cnt <= '0;
                    phase   <= 1'b0;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    if (div_cnt == DIV_MAX) begin
                        div_cnt <= '0;
                        phase   <= ~phase;
                        if (phase) begin
                            if (bit_cnt == '0) begin
                                state <= LATCH;
                            end else begin
                                sr      <= {sr[FB-2:0], 1'b0};
                                bit_cnt <= bit_cnt - 1'b1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                LATCH: begin
                    if (div_cnt == DIV_MAX) begin
                        div_cnt <= '0;
                        phase   <= ~phase;
                        if (phase) begin
                            done_q <= 1'b1;
                            state  <= AUTO ? LOAD : IDLE;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode from state; done cycle reports not busy
    assign ser_data  = (state == SHIFT) & sr[FB-1];
    assign ser_clk   = (state == SHIFT) & phase;
    assign ser_latch = (state == LATCH);
    assign busy      = (state != IDLE) & ~done_q;
    assign done      = done_q;

endmodule

// File: tb/tb_disp_serializer.sv
// Directed bench for disp_serializer: default, inverted-polarity
// and auto-refresh instances driven from a vector table.
module tb_disp_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_m, rst_x;
    logic [15:0] bcd;
    logic [3:0]  dp;
    logic        blz;
    logic        start_m, start_i;

    logic m_sd, m_sc, m_sl, m_busy, m_done;
    logic i_sd, i_sc, i_sl, i_busy, i_done;
    logic a_sd, a_sc, a_sl, a_busy, a_done;

    logic [23:0] a_bcd   = 24'h123456;
    logic [5:0]  a_dp    = 6'b0;
    logic        a_blz   = 1'b0;
    logic        a_start = 1'b0;

    disp_serializer #(
        .NUM_DIGITS(4), .CLK_DIV(2), .ACTIVE_LOW(1'b0), .AUTO(1'b0)
    ) u_main (
        .clk(clk), .rst(rst_m), .bcd_in(bcd), .dp_in(dp),
        .blank_lz(blz), .start(start_m), .ser_data(m_sd),
        .ser_clk(m_sc), .ser_latch(m_sl), .busy(m_busy),
        .done(m_done)
    );

    disp_serializer #(
        .NUM_DIGITS(4), .CLK_DIV(2), .ACTIVE_LOW(1'b1), .AUTO(1'b0)
    ) u_inv (
        .clk(clk), .rst(rst_x), .bcd_in(bcd), .dp_in(dp),
        .blank_lz(blz), .start(start_i), .ser_data(i_sd),
        .ser_clk(i_sc), .ser_latch(i_sl), .busy(i_busy),
        .done(i_done)
    );

    disp_serializer #(
        .NUM_DIGITS(6), .CLK_DIV(1), .ACTIVE_LOW(1'b0), .AUTO(1'b1)
    ) u_auto (
        .clk(clk), .rst(rst_x), .bcd_in(a_bcd), .dp_in(a_dp),
        .blank_lz(a_blz), .start(a_start), .ser_data(a_sd),
        .ser_clk(a_sc), .ser_latch(a_sl), .busy(a_busy),
        .done(a_done)
    );

    int   sel;
    logic s_sd, s_sc, s_sl, s_busy, s_done;

    always_comb begin
        s_sd = m_sd; s_sc = m_sc; s_sl = m_sl;
        s_busy = m_busy; s_done = m_done;
        if (sel == 1) begin
            s_sd = i_sd; s_sc = i_sc; s_sl = i_sl;
            s_busy = i_busy; s_done = i_done;
        end else if (sel == 2) begin
            s_sd = a_sd; s_sc = a_sc; s_sl = a_sl;
            s_busy = a_busy; s_done = a_done;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse start; returns in the LOAD cycle
    task automatic kick(input int s);
        sel = s;
        @(negedge clk);
        if (s == 0) start_m = 1'b1; else start_i = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        start_i = 1'b0;
    endtask

    // From the LOAD cycle: collect bits on ser_clk rises until done
    task automatic capture(input int s, input int poke,
                           output logic [47:0] bits, output int n,
                           output int t, output int lat);
        logic pclk;
        sel  = s;
        bits = '0; n = 0; t = 0; lat = 0;
        pclk = 1'b0;
        while (t < 1000) begin
            @(negedge clk);
            t++;
            if (t == poke) begin
                bcd = 16'h9999; start_m = 1'b1;
            end else if (t == poke + 1) begin
                start_m = 1'b0;
            end
            if (s_sc && !pclk) begin
                bits = {bits[46:0], s_sd};
                n++;
            end
            pclk = s_sc;
            if (s_sl) lat++;
            if (s_done) break;
        end
    endtask

    typedef struct {
        logic [15:0] bcd;
        logic [3:0]  dp;
        logic        blz;
        int          s;
        logic [31:0] exp;
    } vec_t;

    vec_t tv[9];

    initial begin
        logic [47:0] bits;
        int n, t, lat, cnt;

        tv[0] = '{16'h1234, 4'h0, 1'b0, 0, 32'h065B4F66};
        tv[1] = '{16'h0050, 4'h0, 1'b1, 0, 32'h00006D3F};
        tv[2] = '{16'h0050, 4'h0, 1'b0, 0, 32'h3F3F6D3F};
        tv[3] = '{16'h0007, 4'h2, 1'b1, 0, 32'h0000BF07};
        tv[4] = '{16'hBAC0, 4'h0, 1'b1, 0, 32'h0040793F};
        tv[5] = '{16'h0000, 4'h0, 1'b1, 0, 32'h0000003F};
        tv[6] = '{16'h8F09, 4'hF, 1'b0, 0, 32'hFFF9BFEF};
        tv[7] = '{16'h1234, 4'h0, 1'b0, 1, 32'hF9A4B099};
        tv[8] = '{16'h0050, 4'h0, 1'b1, 1, 32'hFFFF92C0};

        sel = 0;
        rst_m = 1'b1; rst_x = 1'b1;
        bcd = '0; dp = '0; blz = 1'b0;
        start_m = 1'b0; start_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_main", {m_sd, m_sc, m_sl, m_busy, m_done}, 0);
        chk("reset_inv", {i_sd, i_sc, i_sl, i_busy, i_done}, 0);
        chk("reset_auto", {a_sd, a_sc, a_sl, a_busy, a_done}, 0);
        rst_m = 1'b0; rst_x = 1'b0;

        for (int i = 0; i < 9; i++) begin
            bcd = tv[i].bcd; dp = tv[i].dp; blz = tv[i].blz;
            kick(tv[i].s);
            chk($sformatf("busy_load_%0d", i), s_busy, 1);
            capture(tv[i].s, -1, bits, n, t, lat);
            chk($sformatf("frame_%0d", i), bits[31:0], tv[i].exp);
            chk($sformatf("nbits_%0d", i), n, 32);
            chk($sformatf("len_%0d", i), t, 133);
            chk($sformatf("latch_%0d", i), lat, 4);
        end

        // start in the done cycle is accepted
        bcd = 16'h1234; dp = '0; blz = 1'b0;
        kick(0);
        capture(0, -1, bits, n, t, lat);
        start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        chk("start_on_done", m_busy, 1);
        capture(0, -1, bits, n, t, lat);
        chk("frame_after_done", bits[31:0], 32'h065B4F66);
        chk("len_after_done", t, 133);

        // input change and start mid-shift are ignored
        bcd = 16'h1234;
        kick(0);
        capture(0, 40, bits, n, t, lat);
        chk("frame_midchg", bits[31:0], 32'h065B4F66);
        chk("len_midchg", t, 133);
        repeat (6) @(negedge clk);
        chk("start_not_queued", m_busy, 0);

        // reset at bit 10 abandons the frame
        bcd = 16'h1234;
        kick(0);
        cnt = 0; t = 0;
        begin
            logic pclk;
            pclk = 1'b0;
            while (cnt < 10 && t < 500) begin
                @(negedge clk);
                t++;
                if (m_sc && !pclk) cnt++;
                pclk = m_sc;
            end
        end
        chk("reach_bit10", cnt, 10);
        rst_m = 1'b1;
        @(negedge clk);
        chk("midframe_rst", {m_sd, m_sc, m_sl, m_busy, m_done}, 0);
        rst_m = 1'b0;
        cnt = 0;
        repeat (300) begin
            @(negedge clk);
            if (m_sl || m_done || m_busy) cnt++;
        end
        chk("no_latch_after_rst", cnt, 0);

        // auto-refresh: back-to-back frames, done coincides with LOAD
        sel = 2;
        t = 0;
        while (!a_done && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("auto_first_done", a_done, 1);
        for (int f = 0; f < 2; f++) begin
            capture(2, -1, bits, n, t, lat);
            chk($sformatf("auto_frame_%0d", f), bits,
                48'h065B4F666D7D);
            chk($sformatf("auto_nbits_%0d", f), n, 48);
            chk($sformatf("auto_period_%0d", f), t, 99);
            chk($sformatf("auto_latch_%0d", f), lat, 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
